// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Holds the serializer state encoding, default bus addresses and status bit positions.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic [9:0] UART_TX_ADDR   = 10'h002;
   localparam logic [9:0] UART_STAT_ADDR = 10'h004;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head word is presented combinationally so a pop consumes it the same cycle.
// Backpressure: none internally -- the caller must only push when not full or when popping that cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// CPU-store-fed 8N1 UART transmitter with FIFO and polled status; tx falls one cycle after a store to an idle block.
// Stores into a full FIFO are dropped and flagged in sticky ovf; status readback has one cycle of latency.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [9:0]  TX_ADDR    = UART_TX_ADDR,
   parameter logic [9:0]  STAT_ADDR  = UART_STAT_ADDR
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [9:0]   mem_addr,
   input  logic [15:0]  wr_data,
   input  logic         mem_wr,
   output logic [15:0]  rd_data,
   output logic         rd_hit,
   output logic         tx
);

   localparam int             BW        = $clog2(CLK_DIV);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);

   tx_state_t       state_q, state_nxt;
   logic [BW-1:0]   baud_q, baud_nxt;
   logic [2:0]      bit_q, bit_nxt;
   logic [7:0]      shreg_q, shreg_nxt;
   logic            tx_nxt;
   logic            baud_end;
   logic            pop;

   logic            push_req, push_ok, clr_req, stat_rd;
   logic            ovf_q;
   logic [7:0]      fifo_dat;
   logic            fifo_full, fifo_empty;
   logic [15:0]     status;

   logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
   logic                        unused_wr_hi;

   assign unused_wr_hi = ^wr_data[15:8];

   assign push_req = mem_wr && (mem_addr == TX_ADDR);
   assign push_ok  = push_req && (!fifo_full || pop);
   assign clr_req  = mem_wr && (mem_addr == STAT_ADDR);
   assign stat_rd  = !mem_wr && (mem_addr == STAT_ADDR);
   assign baud_end = (baud_q == BAUD_LAST);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_ok),
      .wr_data (wr_data[7:0]),
      .pop     (pop),
      .rd_data (fifo_dat),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (unused_fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      baud_nxt  = baud_end ? '0 : baud_q + BW'(1);
      bit_nxt   = bit_q;
      shreg_nxt = shreg_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            baud_nxt = '0;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shreg_nxt = fifo_dat;
               state_nxt = START;
            end
         end
         START: begin
            if (baud_end) begin
               bit_nxt   = '0;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (baud_end) begin
               shreg_nxt = shreg_q >> 1;
               bit_nxt   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            // Chain straight into the next start bit so frames stay contiguous.
            if (baud_end) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shreg_nxt = fifo_dat;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Line level is decided from next-cycle state so tx leaves a flop.
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx      <= 1'b1;
      end else begin
         baud_q  <= baud_nxt;
         bit_q   <= bit_nxt;
         shreg_q <= shreg_nxt;
         tx      <= tx_nxt;
      end
   end

   always_comb begin
      status             = '0;
      status[STAT_EMPTY] = fifo_empty;
      status[STAT_FULL]  = fifo_full;
      status[STAT_BUSY]  = (state_q != IDLE);
      status[STAT_OVF]   = ovf_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q   <= 1'b0;
         rd_data <= '0;
         rd_hit  <= 1'b0;
      end else begin
         if (push_req && !push_ok) ovf_q <= 1'b1;
         else if (clr_req)         ovf_q <= 1'b0;
         if (stat_rd) rd_data <= status;
         rd_hit <= stat_rd;
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx_mmio;

   localparam int CD = 4;
   localparam logic [9:0] TXA = 10'h002;
   localparam logic [9:0] STA = 10'h004;

   logic        clk;
   logic        rst_n;
   logic [9:0]  mem_addr;
   logic [15:0] wr_data;
   logic        mem_wr;
   logic [15:0] rd_data;
   logic        rd_hit;
   logic        tx;

   int checks = 0;
   int errors = 0;

   logic       samp [0:299];
   logic [7:0] exp_q [$];

   uart_tx_mmio #(
      .CLK_DIV    (CD),
      .FIFO_DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_addr (mem_addr),
      .wr_data  (wr_data),
      .mem_wr   (mem_wr),
      .rd_data  (rd_data),
      .rd_hit   (rd_hit),
      .tx       (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic st(input logic [9:0] a, input logic [15:0] d);
      mem_addr = a;
      wr_data  = d;
      mem_wr   = 1'b1;
      @(posedge clk);
      #1;
      mem_wr   = 1'b0;
      mem_addr = 10'h000;
   endtask

   task automatic rd(input logic [9:0] a);
      mem_addr = a;
      mem_wr   = 1'b0;
      @(posedge clk);
      #1;
      mem_addr = 10'h000;
   endtask

   task automatic sample(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         samp[i] = tx;
      end
   endtask

   // Expected line: idle 1 before 'first', then back-to-back frames of exp_q, then idle 1.
   task automatic check_stream(input string tag, input int first, input int total);
      for (int i = 0; i < total; i++) begin
         logic       e;
         logic [7:0] b;
         int         idx, f, bp;
         e = 1'b1;
         if (i >= first) begin
            idx = i - first;
            f   = idx / (10 * CD);
            bp  = (idx % (10 * CD)) / CD;
            if (f < exp_q.size()) begin
               b = exp_q[f];
               if (bp == 0)      e = 1'b0;
               else if (bp == 9) e = 1'b1;
               else              e = b[bp-1];
            end
         end
         chk($sformatf("%s[%0d]", tag, i), {15'b0, samp[i]}, {15'b0, e});
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      mem_wr   = 1'b0;
      mem_addr = 10'h000;
      wr_data  = 16'h0000;
      #12;
      chk("reset_tx", {15'b0, tx}, 16'h0001);
      chk("reset_rd_hit", {15'b0, rd_hit}, 16'h0000);
      chk("reset_rd_data", rd_data, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Idle status read, one-cycle hit, hold, and a miss on a neighbouring address
      rd(STA);
      chk("idle_rd_hit", {15'b0, rd_hit}, 16'h0001);
      chk("idle_rd_data", rd_data, 16'h0001);
      @(posedge clk);
      #1;
      chk("idle_rd_hit_drop", {15'b0, rd_hit}, 16'h0000);
      chk("idle_rd_data_hold", rd_data, 16'h0001);
      rd(10'h006);
      chk("miss_rd_hit", {15'b0, rd_hit}, 16'h0000);
      chk("miss_rd_data_hold", rd_data, 16'h0001);

      // Single frame 0xA5: tx still high right after the store edge, falls on the next
      st(TXA, 16'h00A5);
      chk("a5_no_fall_at_store", {15'b0, tx}, 16'h0001);
      sample(42);
      exp_q = '{8'hA5};
      check_stream("a5", 1, 42);
      rd(STA);
      chk("a5_done_status", rd_data, 16'h0001);

      // Six stores while idle: 0x11 drains at once, 0x12..0x15 fill, 0x16 overflows
      fork
         begin
            for (int k = 0; k < 6; k++) st(TXA, 16'h0011 + 16'(k));
            rd(STA);
            chk("ovf_status", rd_data, 16'h000E);
            chk("ovf_rd_hit", {15'b0, rd_hit}, 16'h0001);
         end
         sample(210);
      join
      exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      check_stream("burst", 2, 210);

      // Sticky ovf survives idle, then a store to the status address clears it
      rd(STA);
      chk("ovf_sticky", rd_data, 16'h0009);
      st(STA, 16'h0000);
      rd(STA);
      chk("ovf_cleared", rd_data, 16'h0001);

      // Full FIFO with a pop on the same edge as a store: accepted, no overflow
      fork
         begin
            st(TXA, 16'h003C);
            st(TXA, 16'h0081);
            st(TXA, 16'h00FF);
            st(TXA, 16'h0000);
            st(TXA, 16'h005A);
            repeat (36) @(posedge clk);
            #1;
            st(TXA, 16'hFFC3);
            rd(STA);
            chk("pop_push_status", rd_data, 16'h0006);
         end
         sample(260);
      join
      exp_q = '{8'h3C, 8'h81, 8'hFF, 8'h00, 8'h5A, 8'hC3};
      check_stream("pop_push", 2, 260);

      // Asynchronous reset in the middle of data bit 3 with bytes still queued
      st(TXA, 16'h0000);
      st(TXA, 16'h00F0);
      st(TXA, 16'h000F);
      rd(STA);
      chk("busy_status", rd_data, 16'h0004);
      repeat (15) @(posedge clk);
      #1;
      chk("bit3_low", {15'b0, tx}, 16'h0000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tx", {15'b0, tx}, 16'h0001);
      chk("async_rst_rd_data", rd_data, 16'h0000);
      chk("async_rst_rd_hit", {15'b0, rd_hit}, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd(STA);
      chk("post_rst_status", rd_data, 16'h0001);
      sample(60);
      exp_q = {};
      check_stream("post_rst_idle", 0, 60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus, the output-side counterpart to the UART receive path at the same address. A CPU store of a byte to `TX_ADDR` queues it in a small FIFO. A serializer then drives it onto `tx` as 8N1 frames, LSB first. A status word at `STAT_ADDR` lets software poll for free space and detect dropped bytes.

## Interface
- `CLK_DIV`, 16: clocks per serial bit, ≥ 2
- `FIFO_DEPTH`, 4: byte entries, power of two, ≥ 2
- `TX_ADDR`, 10'h002: byte address of the transmit data register
- `STAT_ADDR`, 10'h004: byte address of the status register

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_addr`  in  10  CPU byte address
- `wr_data`  in  16  CPU write data
- `mem_wr`  in  1  CPU write strobe, one cycle per store
- `rd_data`  out  16  registered status readback
- `rd_hit`  out  1  registered; `rd_data` is valid and the top level must select it
- `tx`  out  1  serial output, idle high

## Operation
- **Push:** `mem_wr && mem_addr == TX_ADDR` pushes `wr_data[7:0]`; `wr_data[15:8]` is ignored.
  - The push is accepted if `count < FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and sticky `ovf` is set.
- **Clear:** `mem_wr && mem_addr == STAT_ADDR` clears `ovf`. If an overflowing push happens in the same cycle, set wins.
- **Status read:** on any cycle with `!mem_wr && mem_addr == STAT_ADDR`, the next edge loads `rd_data = {12'b0, ovf, busy, full, empty}` and sets `rd_hit = 1`.
  - On every other cycle `rd_hit = 0` and `rd_data` holds its value.
  - Status reflects flags before that edge's update.
- **Definitions:** `busy` = FSM not in IDLE. `full` = `count == FIFO_DEPTH`. `empty` = `count == 0`.
- **FSM states:** IDLE, START, DATA, STOP. Counters are `baud_cnt` (0..CLK_DIV-1) and `bit_cnt` (0..7).
- **IDLE:**
  - `tx = 1`.
  - If the FIFO is non-empty: pop into `shreg`, clear `baud_cnt`, go to START.
- **START:** `tx = 0`. When `baud_cnt == CLK_DIV-1`, go to DATA with `bit_cnt = 0`.
- **DATA:**
  - `tx = shreg[0]`.
  - At the end of each bit: shift right, increment `bit_cnt`.
  - After the end of bit 7, go to STOP.
- **STOP:** `tx = 1`. At the end of the bit:
  - FIFO non-empty: pop and go directly to START (no idle gap).
  - FIFO empty: go to IDLE.
- **Counter widths:** `baud_cnt` is `$clog2(CLK_DIV)` bits and wraps to 0 at `CLK_DIV-1`. `bit_cnt` is 3 bits.
- **FIFO pointers:** `$clog2(FIFO_DEPTH)` bits, natural wrap. Count is one bit wider.

## Timing
- **Reset values** (async, take effect immediately, including mid-frame):
  - `tx = 1`, `rd_data = 0`, `rd_hit = 0`
  - FIFO empty, `ovf = 0`, state IDLE, counters 0
  - A partially sent frame is abandoned.
- **Latency:** for a store at edge N into an empty, idle block:
  - N: byte enters the FIFO.
  - N+1: FSM pops it and `tx` falls.
  - The frame lasts exactly `10*CLK_DIV` cycles.
- `tx` is driven from a flop; no combinational path from the bus to `tx`.
- Back-to-back frames are contiguous: the stop bit's last cycle is followed directly by the next start bit.
- Status read latency is 1 cycle, matching the memory read latency.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`
  - default address constants `UART_TX_ADDR`, `UART_STAT_ADDR`
  - status bit index constants
- Sub-module `sync_fifo`, parameterised by width and depth, with push, pop, `rd_data`, `full`, `empty` and `count` outputs.
  - Read data is combinational from the head, so a pop latches it the same cycle.

## Test plan
- `CLK_DIV=4`, store 0x00A5 to 0x002: `tx` falls one cycle after the store and holds 0 for 4 clocks. It then sends 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks. Total 40 clocks.
- Six consecutive stores 0x11..0x16 while idle, depth 4:
  - 0x11 is popped one edge after its store, so the FIFO fills with 0x12..0x15 and 0x16 is dropped.
  - Read 0x004 returns 0x0008 plus the busy/full bits.
  - Serial output is 0x11..0x15 with no inter-frame gap.
- With the FIFO full and a pop coinciding with a store: the store is accepted and `ovf` stays 0.
- Store to 0x004 while `ovf = 1`: the next status read shows bit 3 = 0.
- Assert `rst_n = 0` during bit 3 of a frame: `tx = 1` without waiting for a clock edge. After release, the FIFO is empty and no further frame is sent.
- A read of 0x004 when idle and empty returns 0x0001 with `rd_hit = 1` for exactly one cycle. A read of 0x006 leaves `rd_hit = 0`.
